// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_if
//  Purpose  : Bundles the decoder-side inputs and the datapath control
//             outputs of the multi-cycle MIPS sequencing controller.
//  Ports    : master -> decoder/datapath side (drives opcode, funct, beq,
//             MemReady; receives all control strobes, selects and counters)
//             slave  -> controller side (mirror of master)
//  Revision : 1.0  initial release
// ============================================================================
interface mc_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        beq;
  logic        MemReady;

  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  RegDst;
  logic [1:0]  MemToReg;
  logic        MemRead;
  logic        MemWrite;
  logic        AluSrc;
  logic [3:0]  AluCtrl;
  logic [1:0]  ExtOp;
  logic [3:0]  State;
  logic [31:0] CycleCnt;
  logic [31:0] InstrCnt;

  modport master (
    output opcode, funct, beq, MemReady,
    input  PCWrite, PCSrc, IRWrite, RegWrite, RegDst, MemToReg,
           MemRead, MemWrite, AluSrc, AluCtrl, ExtOp, State,
           CycleCnt, InstrCnt
  );

  modport slave (
    input  opcode, funct, beq, MemReady,
    output PCWrite, PCSrc, IRWrite, RegWrite, RegDst, MemToReg,
           MemRead, MemWrite, AluSrc, AluCtrl, ExtOp, State,
           CycleCnt, InstrCnt
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl
//  Purpose  : Multi-cycle sequencing controller for the MIPS datapath. A
//             Moore FSM steps each instruction through FETCH / DECODE / EXEC /
//             MEM / WB and drives the PC, IR, GRF and DM write enables and the
//             datapath mux selects. Data memory completion is handshaked with
//             MemReady.
//  Ports    : clk    - system clock, rising edge
//             reset  - synchronous active-high reset, state -> FETCH
//             bus    - mc_ctrl_if.slave (opcode/funct/beq/MemReady in,
//                      control strobes, selects, State and counters out)
//  Config   : MC_PERF_EN - when defined, CycleCnt/InstrCnt are live counters;
//             otherwise both read constant 0 and no counter flops exist.
//  Revision : 1.0  initial release
// ============================================================================
module mc_ctrl (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4,
    S_MEM_WR = 4'd5,
    S_ALU_WB = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_t;

  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b0001;
  localparam logic [3:0] c_alu_or  = 4'b0010;

  state_t state_q, state_d;

  // Instruction class decode (IR is stable from DECODE onward)
  logic w_rtype, w_addu, w_subu, w_jr, w_ralu;
  logic w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;

  assign w_rtype = (bus.opcode == 6'b000000);
  assign w_addu  = w_rtype && (bus.funct == 6'b100001);
  assign w_subu  = w_rtype && (bus.funct == 6'b100011);
  assign w_jr    = w_rtype && (bus.funct == 6'b001000);
  assign w_ralu  = w_addu || w_subu;
  assign w_ori   = (bus.opcode == 6'b001101);
  assign w_lui   = (bus.opcode == 6'b001111);
  assign w_lw    = (bus.opcode == 6'b100011);
  assign w_sw    = (bus.opcode == 6'b101011);
  assign w_beq   = (bus.opcode == 6'b000100);
  assign w_j     = (bus.opcode == 6'b000010);
  assign w_jal   = (bus.opcode == 6'b000011);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = 2'b00;
    bus.IRWrite  = 1'b0;
    bus.RegWrite = 1'b0;
    bus.RegDst   = 2'b00;
    bus.MemToReg = 2'b00;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.AluSrc   = 1'b0;
    bus.AluCtrl  = c_alu_add;
    bus.ExtOp    = 2'b00;

    case (state_q)
      S_FETCH: begin
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        if (w_ralu || w_ori || w_lui || w_lw || w_sw) state_d = S_EXEC;
        else if (w_beq)                               state_d = S_BRANCH;
        else if (w_j || w_jal || w_jr)                state_d = S_JUMP;
        else                                          state_d = S_FETCH;
      end
      S_EXEC: begin
        if (w_ralu) begin
          bus.AluCtrl = w_subu ? c_alu_sub : c_alu_add;
        end else if (w_ori || w_lui) begin
          // lui relies on rs being $0 so that (0 | imm<<16) is the result
          bus.AluSrc  = 1'b1;
          bus.AluCtrl = c_alu_or;
          bus.ExtOp   = w_lui ? 2'b10 : 2'b00;
        end else begin
          bus.AluSrc  = 1'b1;
          bus.ExtOp   = 2'b01;
        end
        if (w_lw)      state_d = S_MEM_RD;
        else if (w_sw) state_d = S_MEM_WR;
        else           state_d = S_ALU_WB;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        if (bus.MemReady) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 2'b01;
        state_d      = S_FETCH;
      end
      S_ALU_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = w_rtype ? 2'b01 : 2'b00;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        // Only Mealy output: PC loads the target when the ALU reports equal
        bus.AluCtrl = c_alu_sub;
        bus.PCWrite = bus.beq;
        bus.PCSrc   = 2'b01;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite = 1'b1;
        if (w_jr) begin
          bus.PCSrc = 2'b11;
        end else begin
          bus.PCSrc = 2'b10;
          if (w_jal) begin
            // PC already holds the return address (PC+4) since FETCH
            bus.RegWrite = 1'b1;
            bus.RegDst   = 2'b10;
            bus.MemToReg = 2'b10;
          end
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset aborts any in-flight instruction without side effects
    if (reset) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
    end
  end

  assign bus.State = state_q;

`ifdef MC_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if ((state_d == S_FETCH) && (state_q != S_FETCH))
        instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign bus.CycleCnt = cycle_cnt_q;
  assign bus.InstrCnt = instr_cnt_q;
`else
  assign bus.CycleCnt = 32'd0;
  assign bus.InstrCnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl
//  Purpose  : Directed self-checking bench for mc_ctrl. Inputs change and
//             outputs are sampled on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  task automatic test_reset();
    int exp_st[5];
    logic [4:0] en;
    exp_st = '{0, 1, 2, 6, 0};
    reset = 1'b1;
    bus.beq = 1'b0;
    bus.MemReady = 1'b1;
    set_instr(6'b000000, 6'b100001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite};
      total++;
      if (en !== 5'b00000) begin
        bad++;
        $display("FAIL reset_enables cyc%0d: got %b want 00000", i, en);
      end
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (bus.State !== 4'(exp_st[i])) begin
        bad++;
        $display("FAIL addu_state step%0d: got %0d want %0d", i, bus.State, exp_st[i]);
      end
      total++;
      if (bus.RegWrite !== (exp_st[i] == 6)) begin
        bad++;
        $display("FAIL addu_regwrite step%0d: got %b want %b", i, bus.RegWrite, (exp_st[i] == 6));
      end
      if (exp_st[i] == 0) begin
        total++;
        if ({bus.IRWrite, bus.PCWrite, bus.PCSrc} !== 4'b1100) begin
          bad++;
          $display("FAIL fetch_out: got %b want 1100", {bus.IRWrite, bus.PCWrite, bus.PCSrc});
        end
      end
      if (exp_st[i] == 2) begin
        total++;
        if ({bus.AluSrc, bus.AluCtrl} !== 5'b00000) begin
          bad++;
          $display("FAIL addu_exec: got %b want 00000", {bus.AluSrc, bus.AluCtrl});
        end
      end
      if (exp_st[i] == 6) begin
        total++;
        if ({bus.RegDst, bus.MemToReg} !== 4'b0100) begin
          bad++;
          $display("FAIL addu_wb: got %b want 0100", {bus.RegDst, bus.MemToReg});
        end
      end
    end
  endtask

  task automatic test_alu();
    logic [5:0] ops[3];
    logic [5:0] fns[3];
    logic [6:0] exp_ex[3];
    logic [1:0] exp_dst[3];
    ops     = '{6'b000000, 6'b001101, 6'b001111};
    fns     = '{6'b100011, 6'b000000, 6'b000000};
    // {AluSrc, AluCtrl, ExtOp}
    exp_ex  = '{7'b0_0001_00, 7'b1_0010_00, 7'b1_0010_10};
    exp_dst = '{2'b01, 2'b00, 2'b00};
    for (int k = 0; k < 3; k++) begin
      set_instr(ops[k], fns[k]);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.State !== 4'd2 || {bus.AluSrc, bus.AluCtrl, bus.ExtOp} !== exp_ex[k]) begin
        bad++;
        $display("FAIL alu_exec k%0d: got st=%0d %b want st=2 %b", k, bus.State,
                 {bus.AluSrc, bus.AluCtrl, bus.ExtOp}, exp_ex[k]);
      end
      @(negedge clk);
      total++;
      if (bus.State !== 4'd6 || bus.RegWrite !== 1'b1 || bus.RegDst !== exp_dst[k]) begin
        bad++;
        $display("FAIL alu_wb k%0d: got st=%0d rw=%b dst=%b want st=6 rw=1 dst=%b", k,
                 bus.State, bus.RegWrite, bus.RegDst, exp_dst[k]);
      end
      @(negedge clk);
      total++;
      if (bus.State !== 4'd0) begin
        bad++;
        $display("FAIL alu_done k%0d: got st=%0d want 0", k, bus.State);
      end
    end
  endtask

  task automatic test_lw();
    int   exp_st[8];
    logic mr[8];
    exp_st = '{0, 1, 2, 3, 3, 3, 4, 0};
    mr     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    set_instr(6'b100011, 6'b000000);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      bus.MemReady = mr[i];
      #1;
      total++;
      if (bus.State !== 4'(exp_st[i]) || bus.MemRead !== (exp_st[i] == 3) ||
          bus.RegWrite !== (exp_st[i] == 4)) begin
        bad++;
        $display("FAIL lw step%0d: got st=%0d mr=%b rw=%b want st=%0d mr=%b rw=%b", i,
                 bus.State, bus.MemRead, bus.RegWrite, exp_st[i], (exp_st[i] == 3), (exp_st[i] == 4));
      end
      if (exp_st[i] == 2) begin
        total++;
        if ({bus.AluSrc, bus.AluCtrl, bus.ExtOp} !== 7'b1_0000_01) begin
          bad++;
          $display("FAIL lw_exec: got %b want 1000001", {bus.AluSrc, bus.AluCtrl, bus.ExtOp});
        end
      end
      if (exp_st[i] == 4) begin
        total++;
        if ({bus.MemToReg, bus.RegDst} !== 4'b0100) begin
          bad++;
          $display("FAIL lw_wb: got %b want 0100", {bus.MemToReg, bus.RegDst});
        end
      end
    end
    bus.MemReady = 1'b1;
  endtask

  task automatic test_beq();
    for (int b = 1; b >= 0; b--) begin
      set_instr(6'b000100, 6'b000000);
      bus.beq = b[0];
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.State !== 4'd7 || bus.PCWrite !== b[0] || bus.PCSrc !== 2'b01 ||
          bus.AluCtrl !== 4'b0001) begin
        bad++;
        $display("FAIL beq%0d: got st=%0d pcw=%b src=%b alu=%b want st=7 pcw=%b src=01 alu=0001",
                 b, bus.State, bus.PCWrite, bus.PCSrc, bus.AluCtrl, b[0]);
      end
      @(negedge clk);
      total++;
      if (bus.State !== 4'd0) begin
        bad++;
        $display("FAIL beq%0d_done: got st=%0d want 0", b, bus.State);
      end
    end
    bus.beq = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0] ops[3];
    logic [5:0] fns[3];
    logic [7:0] exp_o[3];
    ops   = '{6'b000010, 6'b000011, 6'b000000};
    fns   = '{6'b000000, 6'b000000, 6'b001000};
    // {PCWrite, PCSrc, RegWrite, RegDst, MemToReg}
    exp_o = '{8'b1_10_0_00_00, 8'b1_10_1_10_10, 8'b1_11_0_00_00};
    for (int k = 0; k < 3; k++) begin
      set_instr(ops[k], fns[k]);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.State !== 4'd8 ||
          {bus.PCWrite, bus.PCSrc, bus.RegWrite, bus.RegDst, bus.MemToReg} !== exp_o[k]) begin
        bad++;
        $display("FAIL jump k%0d: got st=%0d %b want st=8 %b", k, bus.State,
                 {bus.PCWrite, bus.PCSrc, bus.RegWrite, bus.RegDst, bus.MemToReg}, exp_o[k]);
      end
      @(negedge clk);
      total++;
      if (bus.State !== 4'd0) begin
        bad++;
        $display("FAIL jump_done k%0d: got st=%0d want 0", k, bus.State);
      end
    end
  endtask

  task automatic test_nop();
    logic [5:0] ops[2];
    ops = '{6'b000000, 6'b111111};
    for (int k = 0; k < 2; k++) begin
      set_instr(ops[k], 6'b000000);
      @(negedge clk);
      total++;
      if (bus.State !== 4'd1 || {bus.PCWrite, bus.IRWrite, bus.RegWrite,
          bus.MemRead, bus.MemWrite} !== 5'b00000) begin
        bad++;
        $display("FAIL nop_decode k%0d: got st=%0d en=%b want st=1 en=00000", k, bus.State,
                 {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead, bus.MemWrite});
      end
      @(negedge clk);
      total++;
      if (bus.State !== 4'd0) begin
        bad++;
        $display("FAIL nop_done k%0d: got st=%0d want 0", k, bus.State);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_instr(6'b101011, 6'b000000);
    bus.MemReady = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (bus.State !== 4'd5 || bus.MemWrite !== 1'b1) begin
      bad++;
      $display("FAIL sw_wait: got st=%0d mw=%b want st=5 mw=1", bus.State, bus.MemWrite);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.MemWrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_mw: got %b want 0", bus.MemWrite);
    end
    @(negedge clk);
    total++;
    if (bus.State !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_state: got %0d want 0", bus.State);
    end
    reset = 1'b0;
    bus.MemReady = 1'b1;
  endtask

  task automatic test_perf();
`ifdef MC_PERF_EN
    logic [5:0] ops[10];
    ops = '{6'h00, 6'h00, 6'b001101, 6'b001101, 6'b001101, 6'b001101,
            6'b101011, 6'b101011, 6'b101011, 6'b101011};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.MemReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_instr(ops[c], 6'b000000);
      @(negedge clk);
    end
    total++;
    if (bus.State !== 4'd0 || bus.InstrCnt !== 32'd3 || bus.CycleCnt !== 32'd10) begin
      bad++;
      $display("FAIL perf_counts: got st=%0d ic=%0d cc=%0d want st=0 ic=3 cc=10",
               bus.State, bus.InstrCnt, bus.CycleCnt);
    end
    dut.cycle_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    total++;
    if (bus.CycleCnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_wrap: got %h want 00000000", bus.CycleCnt);
    end
`else
    repeat (3) @(negedge clk);
    total++;
    if (bus.CycleCnt !== 32'd0 || bus.InstrCnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_off: got cc=%0d ic=%0d want 0 0", bus.CycleCnt, bus.InstrCnt);
    end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu();
    test_lw();
    test_beq();
    test_jump();
    test_nop();
    test_reset_mid();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle decode path with a Moore-style FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. In each state it drives the PC, IR, GRF and DM write enables and the datapath mux selects. It sits between the Decoder outputs (opcode/funct) and the shared ALU, GRF, DM and PC registers. It also handles a ready handshake from data memory.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; state -> FETCH
- opcode  in  6  Instr[31:26] from IR (stable after FETCH)
- funct  in  6  Instr[5:0] from IR
- beq  in  1  ALU equal flag (RD1 == RD2), combinational
- MemReady  in  1  DM completion; tie 1 for single-cycle DM
- PCWrite  out  1  load PC from PCSrc mux
- PCSrc  out  2  00 PC+4, 01 branch target (PC+4+(sext imm16<<2)), 10 {PC[31:28],imm26,2'b0}, 11 RD1
- IRWrite  out  1  load IR from IM
- RegWrite  out  1  GRF write enable
- RegDst  out  2  00 rt, 01 rd, 10 5'd31
- MemToReg  out  2  00 ALU result reg, 01 MDR, 10 PC (already PC+4)
- MemRead  out  1  DM read request
- MemWrite  out  1  DM write request
- AluSrc  out  1  0 RD2, 1 imm32
- AluCtrl  out  4  0000 add, 0001 sub, 0010 or
- ExtOp  out  2  00 zero, 01 sign, 10 upper (imm16<<16)
- State  out  4  current state, for debug/verification
- CycleCnt, InstrCnt  out  32 each  perf counters (see Configuration)

## Operation
- Supported instructions: addu, subu, jr (R-type, opcode 000000, funct 100001/100011/001000); ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
- Any other opcode/funct combination is a nop. This includes sll $0 (all-zero word). A nop goes DECODE -> FETCH with no writes.
- States (encoding): FETCH 0, DECODE 1, EXEC 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, ALU_WB 6, BRANCH 7, JUMP 8.
- FETCH: IRWrite=1, PCWrite=1, PCSrc=00. Next state is DECODE.
- DECODE: no enables. Next state by instruction class:
  - R-ALU, ori, lui, lw, sw -> EXEC
  - beq -> BRANCH
  - j, jal, jr -> JUMP
  - nop -> FETCH
- EXEC: R-ALU uses AluSrc=0, AluCtrl from funct. ori uses ExtOp=00, AluCtrl=or. lui uses ExtOp=10, AluCtrl=or with A forced by zero-reg rs. lw/sw use ExtOp=01, AluCtrl=add. Next state: lw -> MEM_RD, sw -> MEM_WR, others -> ALU_WB.
- MEM_RD: MemRead=1. Hold while MemReady=0, then go to MEM_WB (MDR captured by datapath).
- MEM_WR: MemWrite=1. Hold while MemReady=0, then go to FETCH.
- MEM_WB: RegWrite=1, RegDst=00, MemToReg=01. Next state FETCH.
- ALU_WB: RegWrite=1, MemToReg=00, RegDst=01 for R-type and 00 for ori/lui. Next state FETCH.
- BRANCH: AluCtrl=sub. PCWrite=beq (the only Mealy output), PCSrc=01. Next state FETCH.
- JUMP:
  - j: PCWrite=1, PCSrc=10.
  - jal: PCWrite=1, PCSrc=10, plus RegWrite=1, RegDst=10, MemToReg=10.
  - jr: PCWrite=1, PCSrc=11.
  - Next state FETCH.
- All outputs not listed for a state are 0.

## Timing
- Latency in cycles: nop 2; beq/j/jal/jr 3; ALU ops and sw 4; lw 5. Each MEM state adds one cycle per MemReady=0 cycle.
- Reset behaviour:
  - While reset=1, PCWrite, IRWrite, RegWrite, MemRead and MemWrite are forced 0 combinationally.
  - The next edge loads FETCH. State reads 0 after that edge.
- Reset mid-instruction (including MEM wait) aborts the instruction with no further writes.
- MemReady is sampled only in MEM_RD/MEM_WR and ignored elsewhere. MemRead/MemWrite stay asserted and constant throughout a wait.
- jal in JUMP writes $31 with PC, which already holds PC+4 since FETCH.

## Configuration
- MC_PERF_EN defined:
  - CycleCnt increments every non-reset cycle.
  - InstrCnt increments on every transition into FETCH from a non-FETCH state (nop counts).
  - Both clear on reset and wrap at 2^32 to 0.
- MC_PERF_EN undefined: CycleCnt and InstrCnt are constant 0 and no counter flops are generated.

## Test plan
- Reset held 3 cycles, then released with an addu word (opcode 0, funct 100001) -> all enables 0 during reset. State sequence 0,1,2,6,0; RegWrite=1 with RegDst=01 only in state 6.
- lw with MemReady low for 2 cycles -> states 0,1,2,3,3,3,4,0. MemRead high for 3 cycles; RegWrite=1 with MemToReg=01 in state 4.
- beq with beq=1, then beq=0 -> state 7 both times. PCWrite=1/PCSrc=01 in the first case and PCWrite=0 in the second; 3 cycles each.
- jal, then jr -> in state 8, jal shows PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemToReg=10; jr shows PCSrc=11 and RegWrite=0.
- Reset asserted in MEM_WR with MemReady=0 -> MemWrite drops to 0 that cycle and State=0 after the edge.
- With MC_PERF_EN, run nop, ori, sw (MemReady=1) -> after returning to FETCH, InstrCnt=3 and CycleCnt=10. Preload CycleCnt=32'hFFFFFFFF, advance one cycle -> CycleCnt=0.
